// File: rtl/prbs31_check_pkg.sv
// ============================================================================
// Module      : prbs31_check_pkg
// Description : Shared constants for the PRBS31 checker: polynomial, history
//               width and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prbs31_check_pkg;

    localparam int unsigned c_HIST_W = 31;

    // x^31 + x^28 + 1; bit k set means the bit k positions back is a tap,
    // the x^31 term is implicit.
    localparam logic [c_HIST_W-1:0] c_PRBS31_POLY = 31'h10000001;

    localparam int unsigned         c_ST_W      = 2;
    localparam logic [c_ST_W-1:0]   c_ST_HUNT   = 2'd0;
    localparam logic [c_ST_W-1:0]   c_ST_SYNC   = 2'd1;
    localparam logic [c_ST_W-1:0]   c_ST_LOCKED = 2'd2;

    // Words needed before the history holds only received bits.
    function automatic int unsigned fill_words(input int unsigned width);
        return (c_HIST_W + width - 1) / width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prbs31_check_predict.sv
// ============================================================================
// Module      : prbs31_check_predict
// Description : Combinational PRBS31 word predictor fed from received history.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prbs31_check_predict
    import prbs31_check_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [c_HIST_W-1:0]   i_hist,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_expected,
    output logic [c_HIST_W-1:0]   o_hist_next
);

    // Lower index is later in time; w_stream[j+k] lies k bits before w_stream[j].
    logic [c_HIST_W+DATA_WIDTH-1:0] w_stream;

    assign w_stream    = {i_hist, i_data};
    assign o_hist_next = w_stream[c_HIST_W-1:0];

    for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
        logic w_bit;

        always_comb begin
            w_bit = w_stream[b + c_HIST_W];
            for (int k = 1; k < c_HIST_W; k++) begin
                if (c_PRBS31_POLY[k]) begin
                    w_bit = w_bit ^ w_stream[b + k];
                end
            end
        end

        assign o_expected[b] = w_bit;
    end

endmodule

`default_nettype wire

// File: rtl/prbs31_check.sv
// ============================================================================
// Module      : prbs31_check
// Description : Self-synchronizing PRBS31 checker with lock qualification,
//               per-word error pulse and saturating bit-error counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prbs31_check
    import prbs31_check_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned LOCK_COUNT   = 16,
    parameter int unsigned UNLOCK_COUNT = 4,
    parameter int unsigned COUNT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   data_in_valid,
    input  logic                   err_clr,
    output logic                   locked,
    output logic                   bit_err,
    output logic [COUNT_WIDTH-1:0] error_count
);

    localparam int unsigned c_FILL   = fill_words(DATA_WIDTH);
    localparam int unsigned c_FILL_W = $clog2(c_FILL + 1);
    localparam int unsigned c_GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned c_BAD_W  = $clog2(UNLOCK_COUNT + 1);
    localparam int unsigned c_POP_W  = $clog2(DATA_WIDTH + 1);
    localparam int unsigned c_SUM_W  = ((COUNT_WIDTH > c_POP_W) ? COUNT_WIDTH : c_POP_W) + 1;

    localparam logic [c_FILL_W-1:0] c_FILL_LAST = c_FILL_W'(c_FILL - 1);
    localparam logic [c_GOOD_W-1:0] c_GOOD_MAX  = c_GOOD_W'(LOCK_COUNT);
    localparam logic [c_BAD_W-1:0]  c_BAD_MAX   = c_BAD_W'(UNLOCK_COUNT);
    localparam logic [c_SUM_W-1:0]  c_CNT_MAX   = {{(c_SUM_W-COUNT_WIDTH){1'b0}}, {COUNT_WIDTH{1'b1}}};

    logic [c_ST_W-1:0]      r_state,    w_state_nxt;
    logic [c_FILL_W-1:0]    r_fill,     w_fill_nxt;
    logic [c_GOOD_W-1:0]    r_good_cnt, w_good_nxt;
    logic [c_BAD_W-1:0]     r_bad_cnt,  w_bad_nxt;
    logic [c_HIST_W-1:0]    r_hist,     w_hist_next;
    logic                   r_locked;
    logic                   r_bit_err,  w_bit_err_nxt;
    logic [COUNT_WIDTH-1:0] r_err_cnt,  w_count_sat;
    logic                   w_count_add;

    logic [DATA_WIDTH-1:0]  w_expected;
    logic [DATA_WIDTH-1:0]  w_mismatch;
    logic                   w_errored;
    logic [c_POP_W-1:0]     w_popcnt;
    logic [c_SUM_W-1:0]     w_sum;

    prbs31_check_predict #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_predict (
        .i_hist      (r_hist),
        .i_data      (data_in),
        .o_expected  (w_expected),
        .o_hist_next (w_hist_next)
    );

    assign w_mismatch = data_in ^ w_expected;
    assign w_errored  = |w_mismatch;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_popcnt = w_popcnt + c_POP_W'(w_mismatch[i]);
        end
    end

    assign w_sum       = c_SUM_W'(r_err_cnt) + c_SUM_W'(w_popcnt);
    assign w_count_sat = (w_sum > c_CNT_MAX) ? {COUNT_WIDTH{1'b1}} : w_sum[COUNT_WIDTH-1:0];

    // State and qualification counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_ST_HUNT;
            r_fill     <= '0;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill     <= w_fill_nxt;
            r_good_cnt <= w_good_nxt;
            r_bad_cnt  <= w_bad_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        w_good_nxt  = r_good_cnt;
        w_bad_nxt   = r_bad_cnt;
        if (data_in_valid) begin
            case (r_state)
                c_ST_HUNT: begin
                    if (r_fill == c_FILL_LAST) begin
                        w_state_nxt = c_ST_SYNC;
                        w_good_nxt  = '0;
                    end else begin
                        w_fill_nxt = r_fill + 1'b1;
                    end
                end
                c_ST_SYNC: begin
                    if (w_errored) begin
                        w_good_nxt = '0;
                    end else begin
                        w_good_nxt = r_good_cnt + 1'b1;
                        if (w_good_nxt == c_GOOD_MAX) begin
                            w_state_nxt = c_ST_LOCKED;
                            w_bad_nxt   = '0;
                        end
                    end
                end
                c_ST_LOCKED: begin
                    if (w_errored) begin
                        w_bad_nxt = r_bad_cnt + 1'b1;
                        // History remains trustworthy, so fall back to SYNC only.
                        if (w_bad_nxt == c_BAD_MAX) begin
                            w_state_nxt = c_ST_SYNC;
                            w_good_nxt  = '0;
                        end
                    end else begin
                        w_bad_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_HUNT;
                end
            endcase
        end
    end

    always_comb begin
        w_bit_err_nxt = data_in_valid && w_errored &&
                        ((r_state == c_ST_SYNC) || (r_state == c_ST_LOCKED));
        w_count_add   = data_in_valid && w_errored && (r_state == c_ST_LOCKED);
    end

    // Registered outputs and received-bit history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist    <= '0;
            r_locked  <= 1'b0;
            r_bit_err <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (data_in_valid) begin
                r_hist <= w_hist_next;
            end
            r_locked  <= (w_state_nxt == c_ST_LOCKED);
            r_bit_err <= w_bit_err_nxt;
            if (err_clr) begin
                r_err_cnt <= '0;
            end else if (w_count_add) begin
                r_err_cnt <= w_count_sat;
            end
        end
    end

    assign locked      = r_locked;
    assign bit_err     = r_bit_err;
    assign error_count = r_err_cnt;

endmodule

`default_nettype wire
